// File: rtl/hc00_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hc00_tester_pkg
//  Description : Shared types, constants and the vector-lookup function for
//                the quad 2-input NAND tester. The optional crosstalk vector
//                set is enabled with the HC00_TESTER_XTALK_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
package hc00_tester_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        HC00_IDLE   = 3'd0,
        HC00_DRIVE  = 3'd1,
        HC00_SETTLE = 3'd2,
        HC00_SAMPLE = 3'd3,
        HC00_DONE   = 3'd4
    } hc00_state_t;

    localparam int HC00_VEC_BASE       = 4;
    localparam int HC00_VEC_XTALK      = 4;
    localparam int HC00_SETTLE_DEFAULT = 4;

`ifdef HC00_TESTER_XTALK_EN
    localparam int HC00_VEC_COUNT = HC00_VEC_BASE + HC00_VEC_XTALK;
    localparam int HC00_IDX_W     = 3;
`else
    localparam int HC00_VEC_COUNT = HC00_VEC_BASE;
    localparam int HC00_IDX_W     = 2;
`endif

    typedef logic [HC00_IDX_W-1:0] hc00_idx_t;

    // Index of the final vector; the SAMPLE state compares against it
    localparam hc00_idx_t HC00_IDX_LAST = hc00_idx_t'(HC00_VEC_COUNT - 1);

    // One test vector: A and B pin values for gates 3..0
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } hc00_vec_t;

    // Map a vector index to the pin pattern applied to all four gates.
    // Base vectors walk AB through 00, 01, 10, 11 on every gate at once.
    // Crosstalk vectors hold B high and give neighbouring / paired gates
    // opposite A values, so a bridge between their outputs shows up.
    function automatic hc00_vec_t hc00_vec_lookup(input hc00_idx_t idx);
        hc00_vec_t v;
        v.a = {4{idx[1]}};
        v.b = {4{idx[0]}};
`ifdef HC00_TESTER_XTALK_EN
        if (idx[2]) begin
            v.b = 4'b1111;
            case (idx[1:0])
                2'd0:    v.a = 4'b0101;
                2'd1:    v.a = 4'b1010;
                2'd2:    v.a = 4'b0011;
                default: v.a = 4'b1100;
            endcase
        end
`endif
        return v;
    endfunction

endpackage : hc00_tester_pkg
`default_nettype wire

// File: rtl/hc00_sync.sv
`default_nettype none
// ============================================================================
//  Module      : hc00_sync
//  Description : Two-flop synchronizer for the asynchronous gate outputs,
//                synchronous active-low reset.
//  Revision    : 1.0  initial release
// ============================================================================
module hc00_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : hc00_sync
`default_nettype wire

// File: rtl/hc00_tester.sv
`default_nettype none
// ============================================================================
//  Module      : hc00_tester
//  Description : Sequencer that drives a quad 2-input NAND device through a
//                fixed vector set, waits a settle time after each vector,
//                samples the synchronized outputs and keeps sticky per-gate
//                mismatch flags. Defining HC00_TESTER_XTALK_EN appends four
//                crosstalk vectors that expose bridged outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module hc00_tester
    import hc00_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = HC00_SETTLE_DEFAULT,
    parameter int GATES         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [GATES-1:0] drive_a,
    output logic [GATES-1:0] drive_b,
    input  logic [GATES-1:0] sense_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [GATES-1:0] gate_fail
);

    // Counter preload: SETTLE lasts SETTLE_CYCLES cycles, counting down to 0
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    hc00_state_t      state_q;
    hc00_idx_t        idx_q;
    logic [7:0]       settle_cnt_q;
    logic [GATES-1:0] drive_a_q;
    logic [GATES-1:0] drive_b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [GATES-1:0] gate_fail_q;
    logic [GATES-1:0] gate_fail_d;
    logic [GATES-1:0] sync_y;
    hc00_vec_t        cur_vec;

    hc00_sync #(
        .WIDTH (GATES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sense_y),
        .q_o   (sync_y)
    );

    assign cur_vec = hc00_vec_lookup(idx_q);

    // Sticky flags after folding in this SAMPLE's comparison against ideal NAND
    assign gate_fail_d = gate_fail_q | (sync_y ^ ~(drive_a_q & drive_b_q));

    // Sequencer: state, vector index, settle counter and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HC00_IDLE;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            drive_a_q    <= '0;
            drive_b_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            gate_fail_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                HC00_IDLE: begin
                    drive_a_q <= '0;
                    drive_b_q <= '0;
                    if (start) begin
                        gate_fail_q <= '0;
                        pass_q      <= 1'b0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= HC00_DRIVE;
                    end
                end
                HC00_DRIVE: begin
                    drive_a_q    <= cur_vec.a;
                    drive_b_q    <= cur_vec.b;
                    settle_cnt_q <= SETTLE_LOAD;
                    state_q      <= HC00_SETTLE;
                end
                HC00_SETTLE: begin
                    if (settle_cnt_q == 8'd0) begin
                        state_q <= HC00_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 8'd1;
                    end
                end
                HC00_SAMPLE: begin
                    gate_fail_q <= gate_fail_d;
                    if (idx_q == HC00_IDX_LAST) begin
                        // Result and done are visible together in the DONE cycle
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= ~|gate_fail_d;
                        state_q <= HC00_DONE;
                    end else begin
                        idx_q   <= idx_q + hc00_idx_t'(1);
                        state_q <= HC00_DRIVE;
                    end
                end
                HC00_DONE: begin
                    drive_a_q <= '0;
                    drive_b_q <= '0;
                    state_q   <= HC00_IDLE;
                end
                default: begin
                    state_q <= HC00_IDLE;
                end
            endcase
        end
    end

    assign drive_a   = drive_a_q;
    assign drive_b   = drive_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign gate_fail = gate_fail_q;

endmodule : hc00_tester
`default_nettype wire

// File: tb/tb_hc00_tester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hc00_tester
//  Description : Self-checking bench for hc00_tester. A behavioural device
//                model supplies sense_y (ideal or faulty gates, optional
//                bridge of gates 0/1); expected flags come from walking the
//                vector list with plain NAND arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hc00_tester;

    localparam int S = 4;
`ifdef HC00_TESTER_XTALK_EN
    localparam int NV = 8;
`else
    localparam int NV = 4;
`endif
    localparam int PER_VEC = S + 2;
    localparam int LAT     = 1 + NV * PER_VEC;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] drive_a, drive_b, sense_y, gate_fail;
    logic       busy, done, pass;

    // Per-gate device kind (3 bits each): 0 NAND, 1 stuck0, 2 stuck1, 3 AND, 4 OR, 5 XOR
    logic [11:0] kinds_v  = '0;
    logic        bridge01 = 1'b0;

    logic [3:0] vec_a [8] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'b0101, 4'b1010, 4'b0011, 4'b1100};
    logic [3:0] vec_b [8] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

    int n_cmp = 0;
    int n_bad = 0;

    hc00_tester #(
        .SETTLE_CYCLES (S),
        .GATES         (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .drive_a   (drive_a),
        .drive_b   (drive_b),
        .sense_y   (sense_y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .gate_fail (gate_fail)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dev_y(input logic [3:0] a, input logic [3:0] b,
                                         input logic [11:0] k, input logic br);
        logic [3:0] y;
        logic       t;
        for (int g = 0; g < 4; g++) begin
            case (k[3*g +: 3])
                3'd1:    y[g] = 1'b0;
                3'd2:    y[g] = 1'b1;
                3'd3:    y[g] = a[g] & b[g];
                3'd4:    y[g] = a[g] | b[g];
                3'd5:    y[g] = a[g] ^ b[g];
                default: y[g] = ~(a[g] & b[g]);
            endcase
        end
        if (br) begin
            t    = y[0] & y[1];
            y[0] = t;
            y[1] = t;
        end
        return y;
    endfunction

    always_comb sense_y = dev_y(drive_a, drive_b, kinds_v, bridge01);

    // Expected sticky flags: any vector where the device differs from an ideal NAND
    function automatic logic [3:0] exp_fail(input logic [11:0] k, input logic br);
        logic [3:0] f;
        f = '0;
        for (int v = 0; v < NV; v++)
            f = f | (dev_y(vec_a[v], vec_b[v], k, br) ^ ~(vec_a[v] & vec_b[v]));
        return f;
    endfunction

    // Issue start, follow the run to done, collect observations (no checking here)
    task automatic run_test(input int inj, output int lat, output logic [3:0] gf,
                            output logic ps, output logic [3:0] gf1, output logic ps1,
                            output int busy_err, output int drv_err);
        int cyc;
        int v;
        bit seen;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1; seen = 1'b0; busy_err = 0; drv_err = 0; lat = -1;
        gf = 4'hx; ps = 1'bx;
        gf1 = gate_fail; ps1 = pass;
        while (!seen && cyc < 400) begin
            start = (cyc == inj);
            @(negedge clk);
            if (done) begin
                seen = 1'b1; lat = cyc; gf = gate_fail; ps = pass;
                if (busy) busy_err++;
            end else if (!busy) begin
                busy_err++;
            end
            if (cyc <= NV * PER_VEC && ((cyc - 1) % PER_VEC) != 0) begin
                v = (cyc - 1) / PER_VEC;
                if (drive_a !== vec_a[v] || drive_b !== vec_b[v]) drv_err++;
            end
            @(posedge clk); #1 cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass); end
        n_cmp++; if (gate_fail !== 4'b0) begin n_bad++; $display("FAIL reset_gate_fail: got %b want 0000", gate_fail); end
        n_cmp++; if ({drive_a, drive_b} !== 8'h00) begin n_bad++; $display("FAIL reset_drives: got %h want 00", {drive_a, drive_b}); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ideal;
        int lat, be, de; logic [3:0] gf, gf1; logic ps, ps1;
        kinds_v = '0; bridge01 = 1'b0;
        run_test(0, lat, gf, ps, gf1, ps1, be, de);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL ideal_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (ps !== 1'b1) begin n_bad++; $display("FAIL ideal_pass: got %b want 1", ps); end
        n_cmp++; if (gf !== 4'b0) begin n_bad++; $display("FAIL ideal_gate_fail: got %b want 0000", gf); end
        n_cmp++; if (be !== 0) begin n_bad++; $display("FAIL ideal_busy: got %0d bad cycles want 0", be); end
        n_cmp++; if (de !== 0) begin n_bad++; $display("FAIL ideal_vectors: got %0d bad drive cycles want 0", de); end
        @(negedge clk);
        n_cmp++; if ({drive_a, drive_b, done} !== 9'h0) begin n_bad++; $display("FAIL ideal_after_done: got a=%b b=%b done=%b want 0", drive_a, drive_b, done); end
    endtask

    task automatic test_stuck_gate2;
        int lat, be, de; logic [3:0] gf, gf1; logic ps, ps1;
        kinds_v = 12'd2 << 6; bridge01 = 1'b0;
        run_test(0, lat, gf, ps, gf1, ps1, be, de);
        n_cmp++; if (gf !== 4'b0100) begin n_bad++; $display("FAIL stuck2_gate_fail: got %b want 0100", gf); end
        n_cmp++; if (ps !== 1'b0) begin n_bad++; $display("FAIL stuck2_pass: got %b want 0", ps); end
    endtask

    task automatic test_and_gate0;
        int lat, be, de; logic [3:0] gf, gf1; logic ps, ps1;
        kinds_v = 12'd3; bridge01 = 1'b0;
        run_test(0, lat, gf, ps, gf1, ps1, be, de);
        n_cmp++; if (gf !== 4'b0001) begin n_bad++; $display("FAIL and0_gate_fail: got %b want 0001", gf); end
        n_cmp++; if (ps !== 1'b0) begin n_bad++; $display("FAIL and0_pass: got %b want 0", ps); end
    endtask

    task automatic test_start_ignored_and_rerun;
        int lat, be, de; logic [3:0] gf, gf1; logic ps, ps1;
        kinds_v = 12'd2 << 6; bridge01 = 1'b0;
        run_test(S + 5, lat, gf, ps, gf1, ps1, be, de);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL midstart_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (gf !== 4'b0100) begin n_bad++; $display("FAIL midstart_gate_fail: got %b want 0100", gf); end
        repeat (3) @(posedge clk);
        kinds_v = '0;
        run_test(0, lat, gf, ps, gf1, ps1, be, de);
        n_cmp++; if ({gf1, ps1} !== 5'b0) begin n_bad++; $display("FAIL rerun_clear: got gf=%b pass=%b want 0000/0", gf1, ps1); end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL rerun_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if ({gf, ps} !== 5'b00001) begin n_bad++; $display("FAIL rerun_result: got gf=%b pass=%b want 0000/1", gf, ps); end
    endtask

    task automatic test_reset_midrun;
        int lat, be, de, spurious; logic [3:0] gf, gf1; logic ps, ps1;
        kinds_v = 12'd1 << 3; bridge01 = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({gate_fail, drive_a, drive_b} !== 12'b0010_1111_1111) begin
            n_bad++; $display("FAIL pre_reset_state: got gf=%b a=%b b=%b want 0010/1111/1111", gate_fail, drive_a, drive_b);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, done, pass, gate_fail, drive_a, drive_b} !== 15'b0) begin
            n_bad++; $display("FAIL midrun_reset_outputs: got busy=%b done=%b pass=%b gf=%b a=%b b=%b want all 0",
                              busy, done, pass, gate_fail, drive_a, drive_b);
        end
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        n_cmp++; if (spurious !== 0) begin n_bad++; $display("FAIL midrun_reset_idle: got %0d active cycles want 0", spurious); end
        kinds_v = '0;
        run_test(0, lat, gf, ps, gf1, ps1, be, de);
        n_cmp++; if (lat !== LAT || ps !== 1'b1) begin n_bad++; $display("FAIL after_reset_run: got lat=%0d pass=%b want %0d/1", lat, ps, LAT); end
    endtask

    task automatic test_bridge;
        int lat, be, de; logic [3:0] gf, gf1; logic ps, ps1; logic [3:0] want_gf;
        kinds_v = '0; bridge01 = 1'b1;
`ifdef HC00_TESTER_XTALK_EN
        want_gf = 4'b0011;
`else
        want_gf = 4'b0000;
`endif
        run_test(0, lat, gf, ps, gf1, ps1, be, de);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL bridge_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (gf !== want_gf || ps !== (want_gf == 4'b0)) begin
            n_bad++; $display("FAIL bridge_result: got gf=%b pass=%b want %b/%b", gf, ps, want_gf, want_gf == 4'b0);
        end
        bridge01 = 1'b0;
    endtask

    task automatic test_random;
        int lat, be, de, idle; logic [3:0] gf, gf1; logic ps, ps1; logic [3:0] want;
        for (int it = 0; it < 20; it++) begin
            for (int g = 0; g < 4; g++)
                kinds_v[3*g +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
            bridge01 = ($urandom_range(0, 3) == 0);
            want = exp_fail(kinds_v, bridge01);
            run_test(0, lat, gf, ps, gf1, ps1, be, de);
            n_cmp++; if (gf !== want || ps !== (want == 4'b0)) begin
                n_bad++; $display("FAIL random_%0d_result: got gf=%b pass=%b want %b/%b (kinds=%h br=%b)",
                                  it, gf, ps, want, want == 4'b0, kinds_v, bridge01);
            end
            n_cmp++; if (lat !== LAT || be !== 0 || de !== 0) begin
                n_bad++; $display("FAIL random_%0d_timing: got lat=%0d busy_err=%0d drv_err=%0d want %0d/0/0", it, lat, be, de, LAT);
            end
            idle = $urandom_range(0, 5);
            repeat (idle) @(posedge clk);
            @(negedge clk);
            n_cmp++; if (gate_fail !== want || pass !== (want == 4'b0)) begin
                n_bad++; $display("FAIL random_%0d_hold: got gf=%b pass=%b want %b/%b", it, gate_fail, pass, want, want == 4'b0);
            end
        end
        bridge01 = 1'b0;
        kinds_v  = '0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck_gate2();
        test_and_gate0();
        test_start_ignored_and_rerun();
        test_reset_midrun();
        test_bridge();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hc00_tester
`default_nettype wire

// File: doc/hc00_tester.md
# hc00_tester

Built-in sequencer that exercises an external quad 2-input NAND device (four gates, 74HC00-class) and reports a per-gate pass/fail result. On a `start` pulse it drives every gate through a fixed set of input vectors and waits a programmable settle time after each one. It then samples the synchronized gate outputs, compares them against the expected NAND result and records any mismatch. The block sits between the host control logic and the device-under-test pins on the board.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4, cycles held in SETTLE after each drive; legal range 3..255 (8-bit counter)
- `GATES`, 4, number of gates under test; fixed at 4

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `start`  in  1  one-cycle request to begin a test run; ignored unless in IDLE
- `drive_a`  out  4  A inputs to gates 3..0
- `drive_b`  out  4  B inputs to gates 3..0
- `sense_y`  in  4  raw Y outputs of gates 3..0, asynchronous to `clk`
- `busy`  out  1  high while a run is in progress
- `done`  out  1  one-cycle pulse when a run completes
- `pass`  out  1  high when the last completed run found no mismatch; held until the next `start`
- `gate_fail`  out  4  sticky per-gate mismatch flags for the last run; held until the next `start`

## Operation
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `drive_a` = `drive_b` = 0.
  - `start` = 1 clears `gate_fail`, clears `pass`, sets the vector index to 0, and moves to DRIVE.
- DRIVE, 1 cycle:
  - Registers the vector pattern onto `drive_a`/`drive_b`.
  - Loads the settle counter with `SETTLE_CYCLES`-1.
  - Moves to SETTLE.
- SETTLE:
  - Decrements the counter each cycle.
  - Moves to SAMPLE on the cycle the counter reads 0.
- SAMPLE, 1 cycle:
  - Computes `gate_fail[i] |= sync_y[i] ^ ~(drive_a[i] & drive_b[i])`.
  - If the current vector is the last one, moves to DONE; otherwise increments the index and moves to DRIVE.
- DONE, 1 cycle:
  - `done` = 1, `pass` = ~|`gate_fail` (including this run's final SAMPLE).
  - Forces drives to 0 and returns to IDLE.
- Base vectors, index 0..3: `drive_a` = {4{idx[1]}}, `drive_b` = {4{idx[0]}}, i.e. AB = 00, 01, 10, 11 applied to all gates at once.
- `sense_y` passes through a 2-flop synchronizer; `SETTLE_CYCLES` ≥ 3 guarantees the sampled value reflects the current drive.
- `start` is ignored in any state other than IDLE, including DONE.
- If `rst_n` = 0 is sampled at any time, including mid-run, the next cycle has state = IDLE and every output = 0: `busy`, `done`, `pass`, `gate_fail`, `drive_a`, `drive_b`. No partial result is kept.

## Timing
- Reset values: all outputs 0; synchronizer flops 0.
- `start` sampled high at edge k:
  - `busy` = 1 from cycle k+1 through the final SAMPLE.
  - Each vector takes 2 + `SETTLE_CYCLES` cycles.
  - `done` is high at cycle k+1+N·(2+`SETTLE_CYCLES`), where N = vector count; with defaults, k+25.
  - `busy` falls in the same cycle that `done` rises.
- `pass`/`gate_fail` are valid from the `done` cycle and stable until the cycle after the next accepted `start`.
- Drive outputs are registered: no combinational path from `sense_y` or `start` to any output.

## Configuration
- `HC00_TESTER_XTALK_EN` defined:
  - Appends 4 crosstalk vectors, index 4..7, with `drive_b` = 4'b1111 and `drive_a` = 4'b0101, 4'b1010, 4'b0011, 4'b1100.
  - N = 8; with defaults, `done` at k+49.
  - These vectors detect bridged adjacent or paired outputs.
- Undefined: N = 4; the index counter is 2 bits and the crosstalk logic is absent.

## Structure
- `hc00_tester_pkg` holds:
  - the state enum;
  - `HC00_VEC_BASE` = 4;
  - `HC00_VEC_XTALK` = 4;
  - the vector-lookup function mapping index to {a, b};
  - the default settle constant.
- Sub-module `hc00_sync`: 4-bit two-flop synchronizer with synchronous active-low reset, instantiated once for `sense_y`.
- The FSM, settle counter, vector index and result registers live in the top module.

## Test plan
- Four ideal NAND models, `SETTLE_CYCLES` = 4, `start` at edge k -> `done` at k+25, `pass` = 1, `gate_fail` = 4'b0000, drives return to 0 after `done`.
- Gate 2 output stuck at 1 -> mismatch at vector AB = 11 only; `gate_fail` = 4'b0100, `pass` = 0.
- Gate 0 modelled as AND -> fails all four vectors; `gate_fail` = 4'b0001, `pass` = 0.
- `start` pulsed during SETTLE of vector 1 -> ignored, `done` still at k+25; a second `start` after `done` clears `gate_fail` at k'+1 and reruns with identical timing.
- `rst_n` low for one cycle mid-SETTLE -> next cycle all outputs 0, state IDLE; a subsequent `start` completes normally with `pass` = 1.
- Gates 0 and 1 outputs bridged (wired-AND):
  - Without `HC00_TESTER_XTALK_EN`: `pass` = 1.
  - With it: `done` at k+49 and `gate_fail` = 4'b0011, because vectors 4 and 5 make the ideal outputs of gates 0 and 1 differ, so the bridge fails them.
